imem_arbiter: RTL and testbench

Sequences and shares the single-port instruction memory between the CPU fetch stage and a program loader/debug port. After reset the block stays in a LOAD phase: only the loader may access memory and the CPU is held. On boot completion it switches to RUN, where fetch has priority and the loader is protected from starvation. The block sits between ifetch (via the imem interface) and the synchronous instruction SRAM.

---
 rtl/imem_arbiter.sv | 133 +++++++++++++
 tb/tb_imem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - instruction memory arbiter between CPU fetch and program loader
// LOAD phase grants only the loader; RUN phase favours fetch with bounded loader starvation.
module imem_arbiter #(
    parameter int NB_ADDR    = 32,
    parameter int NB_WORD    = 32,
    parameter int MAX_STARVE = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_boot_done,
    input  logic               i_reload,
    output logic               o_cpu_hold,
    input  logic               i_f_req,
    input  logic [NB_ADDR-1:0] i_f_addr,
    output logic               o_f_gnt,
    output logic               o_f_rvalid,
    output logic [NB_WORD-1:0] o_f_rdata,
    input  logic               i_l_req,
    input  logic               i_l_we,
    input  logic [NB_ADDR-1:0] i_l_addr,
    input  logic [NB_WORD-1:0] i_l_wdata,
    output logic               o_l_gnt,
    output logic               o_l_rvalid,
    output logic [NB_WORD-1:0] o_l_rdata,
    output logic               o_m_en,
    output logic               o_m_we,
    output logic [NB_ADDR-1:0] o_m_addr,
    output logic [NB_WORD-1:0] o_m_wdata,
    input  logic [NB_WORD-1:0] i_m_rdata
);

    localparam int CNT_W = $clog2(MAX_STARVE + 1);
    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(MAX_STARVE);

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]         state;
    logic [0:0]         state_next;
    logic [CNT_W-1:0]   starve_cnt;
    logic [CNT_W-1:0]   starve_next;
    logic               f_gnt;
    logic               l_gnt;
    logic               pend_f;
    logic               pend_l;
    logic [NB_WORD-1:0] f_rdata_q;
    logic [NB_WORD-1:0] l_rdata_q;
    logic               contend;

    assign contend = i_l_req && i_f_req && (starve_cnt < STARVE_LIMIT);

    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (state == ST_LOAD) begin
            l_gnt = i_l_req;
        end else if (contend) begin
            f_gnt = 1'b1;
        end else if (i_l_req) begin
            l_gnt = 1'b1;
        end else begin
            f_gnt = i_f_req;
        end
    end

    always_comb begin
        o_m_en    = 1'b0;
        o_m_we    = 1'b0;
        o_m_addr  = '0;
        o_m_wdata = '0;
        if (f_gnt) begin
            o_m_en   = 1'b1;
            o_m_addr = i_f_addr;
        end else if (l_gnt) begin
            o_m_en    = 1'b1;
            o_m_we    = i_l_we;
            o_m_addr  = i_l_addr;
            o_m_wdata = i_l_wdata;
        end
    end

    // Boot-done only matters in LOAD and reload only in RUN, so a simultaneous pulse resolves by state.
    always_comb begin
        state_next  = state;
        starve_next = '0;
        if (state == ST_LOAD) begin
            if (i_boot_done) begin
                state_next = ST_RUN;
            end
        end else begin
            if (contend) begin
                starve_next = starve_cnt + CNT_W'(1);
            end
            if (i_reload) begin
                state_next  = ST_LOAD;
                starve_next = '0;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= ST_LOAD;
            starve_cnt <= '0;
            pend_f     <= 1'b0;
            pend_l     <= 1'b0;
            f_rdata_q  <= '0;
            l_rdata_q  <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            pend_f     <= f_gnt;
            pend_l     <= l_gnt && !i_l_we;
            if (pend_f) begin
                f_rdata_q <= i_m_rdata;
            end
            if (pend_l) begin
                l_rdata_q <= i_m_rdata;
            end
        end
    end

    // The SRAM returns data in the cycle after the grant, so the owner sees it directly and the
    // register only keeps it stable until that owner's next valid.
    assign o_f_rvalid = pend_f && !i_reset;
    assign o_l_rvalid = pend_l && !i_reset;
    assign o_f_rdata  = o_f_rvalid ? i_m_rdata : f_rdata_q;
    assign o_l_rdata  = o_l_rvalid ? i_m_rdata : l_rdata_q;
    assign o_f_gnt    = f_gnt;
    assign o_l_gnt    = l_gnt;
    assign o_cpu_hold = (state == ST_LOAD);

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - randomized self-checking bench for imem_arbiter against a behavioural model
module tb_imem_arbiter;
    localparam int NB_ADDR    = 32;
    localparam int NB_WORD    = 32;
    localparam int MAX_STARVE = 8;

    logic               clock = 1'b0;
    logic               reset;
    logic               boot_done, reload;
    logic               cpu_hold;
    logic               f_req;
    logic [NB_ADDR-1:0] f_addr;
    logic               f_gnt, f_rvalid;
    logic [NB_WORD-1:0] f_rdata;
    logic               l_req, l_we;
    logic [NB_ADDR-1:0] l_addr;
    logic [NB_WORD-1:0] l_wdata;
    logic               l_gnt, l_rvalid;
    logic [NB_WORD-1:0] l_rdata;
    logic               m_en, m_we;
    logic [NB_ADDR-1:0] m_addr;
    logic [NB_WORD-1:0] m_wdata;
    logic [NB_WORD-1:0] m_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    imem_arbiter #(.NB_ADDR(NB_ADDR), .NB_WORD(NB_WORD), .MAX_STARVE(MAX_STARVE)) dut (
        .i_clock(clock), .i_reset(reset), .i_boot_done(boot_done), .i_reload(reload),
        .o_cpu_hold(cpu_hold),
        .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(f_gnt), .o_f_rvalid(f_rvalid),
        .o_f_rdata(f_rdata),
        .i_l_req(l_req), .i_l_we(l_we), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
        .o_l_gnt(l_gnt), .o_l_rvalid(l_rvalid), .o_l_rdata(l_rdata),
        .o_m_en(m_en), .o_m_we(m_we), .o_m_addr(m_addr), .o_m_wdata(m_wdata),
        .i_m_rdata(m_rdata)
    );

    // Synchronous single-port SRAM, 64 words.
    logic [NB_WORD-1:0] sram [64];
    always @(posedge clock) begin
        if (m_en) begin
            if (m_we) sram[m_addr[7:2]] <= m_wdata;
            else      m_rdata <= sram[m_addr[7:2]];
        end
    end

    // Reference model state
    logic [NB_WORD-1:0] ref_mem [64];
    bit                 ref_loading = 1'b1;
    int                 lost_to_fetch = 0;
    bit                 exp_fv = 1'b0, exp_lv = 1'b0;
    logic [NB_WORD-1:0] exp_fd_next = '0, exp_ld_next = '0;
    logic [NB_WORD-1:0] exp_frd = '0, exp_lrd = '0;

    task automatic check(input string tag, input logic [NB_WORD-1:0] got, input logic [NB_WORD-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called once per cycle with inputs already driven after the falling edge.
    task automatic step();
        bit fg, lg, rv_f, rv_l;
        #1;
        fg = 1'b0;
        lg = 1'b0;
        if (ref_loading) lg = l_req;
        else if (l_req && f_req && lost_to_fetch < MAX_STARVE) fg = 1'b1;
        else if (l_req) lg = 1'b1;
        else fg = f_req;

        rv_f = exp_fv && !reset;
        rv_l = exp_lv && !reset;
        if (rv_f) exp_frd = exp_fd_next;
        if (rv_l) exp_lrd = exp_ld_next;

        check("cpu_hold", 32'(cpu_hold), 32'(ref_loading));
        check("f_gnt",    32'(f_gnt),    32'(fg));
        check("l_gnt",    32'(l_gnt),    32'(lg));
        check("m_en",     32'(m_en),     32'(fg || lg));
        check("m_we",     32'(m_we),     32'(lg && l_we));
        check("m_addr",   m_addr,  fg ? f_addr : (lg ? l_addr : '0));
        check("m_wdata",  m_wdata, lg ? l_wdata : '0);
        check("f_rvalid", 32'(f_rvalid), 32'(rv_f));
        check("l_rvalid", 32'(l_rvalid), 32'(rv_l));
        check("f_rdata",  f_rdata, exp_frd);
        check("l_rdata",  l_rdata, exp_lrd);

        if (reset) begin
            ref_loading   = 1'b1;
            lost_to_fetch = 0;
            exp_fv        = 1'b0;
            exp_lv        = 1'b0;
            exp_frd       = '0;
            exp_lrd       = '0;
        end else begin
            exp_fv = fg;
            exp_lv = lg && !l_we;
            if (fg) exp_fd_next = ref_mem[f_addr[7:2]];
            if (lg && !l_we) exp_ld_next = ref_mem[l_addr[7:2]];
            if (lg && l_we) ref_mem[l_addr[7:2]] = l_wdata;
            if (!ref_loading && l_req && f_req && lost_to_fetch < MAX_STARVE) lost_to_fetch++;
            else lost_to_fetch = 0;
            if (ref_loading) begin
                if (boot_done) ref_loading = 1'b0;
            end else if (reload) begin
                ref_loading   = 1'b1;
                lost_to_fetch = 0;
            end
            if (lost_to_fetch > MAX_STARVE) begin
                bad++;
                $display("FAIL starve_bound: got=%0d exp<=%0d", lost_to_fetch, MAX_STARVE);
            end
        end
        @(negedge clock);
    endtask

    task automatic idle();
        reset = 1'b0; boot_done = 1'b0; reload = 1'b0;
        f_req = 1'b0; f_addr = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        step();
        reset = 1'b0;
        step();

        // Fill the whole memory through the loader so every later read is defined.
        for (int i = 0; i < 64; i++) begin
            l_req = 1'b1; l_we = 1'b1; l_addr = 32'(i * 4); l_wdata = $urandom;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            l_req = 1'b1; l_we = 1'b1; l_addr = 32'(i * 4); l_wdata = 32'h0000_0013;
            step();
        end
        idle();

        // LOAD: fetch request is ignored while the loader reads.
        f_req = 1'b1; f_addr = 32'h0;
        l_req = 1'b1; l_we = 1'b0; l_addr = 32'h4;
        step();
        idle();
        step();
        check("plan_l_rdata", l_rdata, 32'h0000_0013);

        boot_done = 1'b1;
        step();
        idle();
        f_req = 1'b1; f_addr = 32'h8;
        step();
        idle();
        step();
        check("plan_f_rdata", f_rdata, 32'h0000_0013);

        // Continuous contention: loader must get in every MAX_STARVE+1 cycles.
        for (int i = 0; i < 3 * (MAX_STARVE + 1); i++) begin
            f_req = 1'b1; f_addr = 32'($urandom_range(0, 255));
            l_req = 1'b1; l_we = 1'b0; l_addr = 32'($urandom_range(0, 255));
            step();
        end
        idle();
        step();

        // Reload in the same cycle as a fetch grant.
        f_req = 1'b1; f_addr = 32'h8; reload = 1'b1;
        step();
        reload = 1'b0;
        step();
        idle();
        step();

        // Reset right after a loader read grant.
        l_req = 1'b1; l_we = 1'b0; l_addr = 32'h4;
        step();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 800; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            boot_done = ($urandom_range(0, 7) == 0);
            reload    = ($urandom_range(0, 15) == 0);
            f_req     = reset ? 1'b0 : 1'($urandom);
            f_addr    = 32'($urandom_range(0, 255));
            l_req     = reset ? 1'b0 : ($urandom_range(0, 2) != 0);
            l_we      = 1'($urandom);
            l_addr    = 32'($urandom_range(0, 255));
            l_wdata   = $urandom;
            step();
        end
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
